// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared single-transaction resource.
// Holds a grant until done or timeout, then rotates priority past the last winner.
module shared_port_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 start,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   ptr, ptr_n, sel_n, win, nxt;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    gnt_n;
  logic            start_n, busy_n, terr_n, found;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // First requester at or above ptr, wrapping; ptr itself has top priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr, k);
      end
    end
  end

  assign nxt = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    start_n = 1'b0;
    busy_n  = busy;
    terr_n  = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = BUSY;
          gnt_n        = '0;
          gnt_n[win]   = 1'b1;
          sel_n        = win;
          start_n      = 1'b1;
          busy_n       = 1'b1;
          cnt_n        = '0;
        end
      end
      BUSY: begin
        // done takes precedence over a timeout landing in the same cycle
        if (done || cnt == CW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = nxt;
          terr_n  = !done;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      sel         <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      sel         <= sel_n;
      start       <= start_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
    end
  end
endmodule

// File: tb/tb_shared_port_arbiter.sv
// Directed bench for shared_port_arbiter: cycle model plus hand-computed grant orders.
module tb_shared_port_arbiter;
  localparam int N = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic done = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0] sel;
  logic start, busy, timeout_err;

  int total = 0;
  int bad = 0;

  shared_port_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt), .sel(sel),
    .start(start), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource and how many cycles its grant may still last.
  logic [N-1:0] e_gnt = '0;
  int e_sel = 0, m_ptr = 0, m_left = 0;
  logic e_start = 1'b0, e_busy = 1'b0, e_terr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_gnt = '0; e_sel = 0; m_ptr = 0; m_left = 0;
      e_start = 1'b0; e_busy = 1'b0; e_terr = 1'b0;
    end else begin
      e_start = 1'b0;
      e_terr  = 1'b0;
      if (!e_busy) begin
        for (int k = 0; k < N; k++) begin
          if (!e_busy && req[(m_ptr + k) % N]) begin
            e_sel = (m_ptr + k) % N;
            e_busy = 1'b1; e_start = 1'b1; m_left = TIMEOUT;
            e_gnt = '0; e_gnt[e_sel] = 1'b1;
          end
        end
      end else if (done || m_left == 1) begin
        e_terr = !done;
        e_busy = 1'b0; e_gnt = '0;
        m_ptr = (e_sel + 1) % N;
      end else begin
        m_left = m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      total += 5;
      if (gnt !== e_gnt) begin bad++; $display("FAIL gnt act=%b exp=%b t=%0t", gnt, e_gnt, $time); end
      if (sel !== 2'(e_sel)) begin bad++; $display("FAIL sel act=%0d exp=%0d t=%0t", sel, e_sel, $time); end
      if (start !== e_start) begin bad++; $display("FAIL start act=%b exp=%b t=%0t", start, e_start, $time); end
      if (busy !== e_busy) begin bad++; $display("FAIL busy act=%b exp=%b t=%0t", busy, e_busy, $time); end
      if (timeout_err !== e_terr) begin bad++; $display("FAIL timeout_err act=%b exp=%b t=%0t", timeout_err, e_terr, $time); end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Returns at the negedge where start is visible; ok=0 if it never came.
  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (start) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_start act=no_start exp=start"); end
  endtask

  // Wait for a grant, pulse done d cycles after start, load next_req meanwhile.
  task automatic serve(input int d, input logic [N-1:0] next_req, output int s);
    logic ok;
    wait_start(ok);
    s = ok ? int'(sel) : -1;
    repeat (d) @(negedge clk);
    done = 1'b1;
    req  = next_req;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    int s, n;
    logic ok;
    int exp1 [5] = '{0, 1, 2, 3, 0};
    int exp2 [3] = '{1, 3, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);

    repeat (10) @(negedge clk);

    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(2, (i == 4) ? 4'b1010 : 4'b1111, s);
      chk($sformatf("rr_all_%0d", i), s, exp1[i]);
    end

    for (int i = 0; i < 3; i++) begin
      serve(2, (i == 2) ? 4'b0001 : 4'b1010, s);
      chk($sformatf("rr_1010_%0d", i), s, exp2[i]);
    end

    // Requester 0 never completes; requester 1 queues up behind it.
    wait_start(ok);
    chk("to_sel", int'(sel), 0);
    req = 4'b0011;
    n = 0;
    while (gnt == 4'b0001 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", n, TIMEOUT);
    chk("to_err", int'(timeout_err), 1);

    // done lands on the timeout cycle
    serve(TIMEOUT - 1, 4'b0100, s);
    chk("to_next_sel", s, 1);
    chk("done_vs_to_err", int'(timeout_err), 0);
    chk("done_vs_to_gnt", int'(gnt), 0);

    // done alongside start: one-cycle grant
    serve(0, 4'b0100, s);
    chk("short_sel", s, 2);
    chk("short_gnt", int'(gnt), 0);

    // ptr=3 now; requester 2 granted, then reset with its counter at 5
    wait_start(ok);
    chk("rst_pre_sel", int'(sel), 2);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_start", int'(start), 0);
    chk("arst_terr", int'(timeout_err), 0);
    chk("arst_sel", int'(sel), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0100;
    serve(1, 4'b1111, s);
    chk("post_rst_sel", s, 2);
    serve(1, 4'b0000, s);
    chk("post_rst_next", s, 3);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_port_arbiter.md
# shared_port_arbiter

Round-robin arbiter and sequencer granting one shared single-transaction resource (e.g. a combinational decode/mux datapath with a registered result stage) to one of N requesters at a time. It accepts requests and issues a single-cycle start to the resource. It holds the grant until the resource signals done or a timeout expires, then rotates priority. It sits between the requesting agents and the shared resource; the resource sees only `start`, `sel` and returns `done`.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 15: maximum cycles a grant is held without `done`, 1..255.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset (polarity and synchronicity fixed).
- `req`  in  N: request vector, bit i = requester i; level, sampled only in IDLE.
- `done`  in  1: resource completion, 1-cycle pulse; ignored outside BUSY.
- `gnt`  out  N: one-hot grant, all-zero when idle; registered.
- `sel`  out  $clog2(N): index of the granted requester; registered, holds last value when idle.
- `start`  out  1: 1-cycle pulse on the first BUSY cycle.
- `busy`  out  1: high while in BUSY.
- `timeout_err`  out  1: 1-cycle pulse when a grant is released by timeout.

## Operation
- Reset values: state IDLE, `gnt`=0, `sel`=0, `start`=0, `busy`=0, `timeout_err`=0, priority pointer `ptr`=0, timeout counter=0.
- FSM has 2 states:
  - IDLE: if `req` != 0, pick the first set bit searching from `ptr` upward, wrapping N-1 to 0. Go to BUSY with `gnt`=onehot(winner), `sel`=winner, `start`=1, counter=0. If `req`=0, stay in IDLE.
  - BUSY: `start`=0 after its first cycle. If `done`=1, go to IDLE, `gnt`=0, `ptr`=(sel+1) mod N. Else if counter==TIMEOUT-1, go to IDLE, `gnt`=0, `timeout_err`=1 for one cycle, `ptr`=(sel+1) mod N. Else counter+1.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps; it is cleared on every BUSY entry.
- `done` and timeout in the same cycle: `done` wins and `timeout_err` stays 0.
- `done` in the first BUSY cycle (with `start`) is accepted. The grant lasts 1 cycle.
- Requester dropping `req` while granted has no effect. The grant is held until `done` or timeout.
- `req` changes in BUSY are ignored. Arbitration uses `req` as sampled in the IDLE cycle.
- A winner equal to `ptr`-1 (lowest priority) is granted only when it is the sole requester.
- Assertion of `rst` mid-transaction clears everything immediately (asynchronous). The resource sees `gnt`/`start` drop without `done`; no `timeout_err` is generated.

## Timing
- `req` seen in IDLE at cycle t: `gnt`, `sel`, `start`, `busy` valid at t+1.
- `done` at cycle t (in BUSY): `gnt`=0 and `busy`=0 at t+1. The earliest next grant is at t+2 (one mandatory IDLE cycle).
- The grant lasts from 1 to TIMEOUT cycles.
- On timeout, `timeout_err` is high in the same cycle `gnt` first reads 0.
- Throughput under continuous requests: one transaction per (BUSY length + 1) cycles.
- All outputs are registered; there are no combinational paths from `req` or `done` to any output.

## Test plan
- Reset then `req`=4'b0000 for 10 cycles: `gnt`=0, `start`=0, `busy`=0 throughout.
- `req`=4'b1111 held; `done` pulsed 2 cycles after each `start`: grants go 0,1,2,3,0 (`sel`=0,1,2,3,0), each `start` exactly 1 cycle, with 1 IDLE cycle between grants.
- `req`=4'b1010 with `ptr`=2 (after serving requester 1): requester 3 is granted next, then requester 1.
- Grant requester 0 with `done` never asserted, TIMEOUT=15: `gnt`=4'b0001 for exactly 15 cycles, then `timeout_err` pulses for 1 cycle. The next grant goes to requester 1 if requesting.
- `done` coincident with the timeout cycle: release occurs and `timeout_err` stays 0. `done` coincident with `start`: `gnt` is high for 1 cycle.
- `rst` asserted asynchronously mid-BUSY (requester 2 granted, counter=5): all outputs are 0 before the next edge. After release with `req`=4'b0100, requester 2 is granted with `ptr`=0 priority.
